// File: rtl/joy_serial_snac.sv
// Serial joystick reader for a chain of 74HC165-style shift registers.
// Each frame it loads the chain, shifts NUM_PLAYERS*BITS_PER_PLAYER bits and latches decoded pad words.
module joy_serial_snac #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 12,
    parameter int CLK_DIV         = 24,
    parameter int POLL_PERIOD     = 48000
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_PLAYERS-1:0]      player_en,
    input  logic                        JOY_DATA,
    output logic                        JOY_CLK,
    output logic                        JOY_LOAD,
    output logic [16*NUM_PLAYERS-1:0]   joystick,
    output logic [NUM_PLAYERS-1:0]      connected,
    output logic                        frame_strobe
);

    localparam int TOTAL       = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int LOAD_CYCLES = 2 * CLK_DIV;
    localparam int CNT_MAX     = (POLL_PERIOD > LOAD_CYCLES) ? POLL_PERIOD : LOAD_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int K_W         = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t                         r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic [K_W-1:0]                 r_k;
    logic [TOTAL-1:0]               r_raw;
    logic                           r_sync1;
    logic                           r_sync2;
    logic                           r_clk;
    logic                           r_load;
    logic                           r_strobe;
    logic [16*NUM_PLAYERS-1:0]      r_joystick;
    logic [NUM_PLAYERS-1:0]         r_connected;

    logic [NUM_PLAYERS-1:0]         w_det;
    logic [16*NUM_PLAYERS-1:0]      w_joy_next;

    // A floating or absent pad reads all-low, so any high bit means a pad is present.
    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            assign w_det[gi] = |r_raw[gi*BITS_PER_PLAYER +: BITS_PER_PLAYER];
            for (genvar gb = 0; gb < 16; gb++) begin : g_bit
                if (gb < BITS_PER_PLAYER) begin : g_used
                    assign w_joy_next[16*gi+gb] = ~r_raw[gi*BITS_PER_PLAYER+gb] & w_det[gi] & player_en[gi];
                end else begin : g_unused
                    assign w_joy_next[16*gi+gb] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        r_sync1  <= JOY_DATA;
        r_sync2  <= r_sync1;
        r_strobe <= 1'b0;
        if (reset || !enable) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_k         <= '0;
            r_load      <= 1'b1;
            r_clk       <= 1'b0;
            r_joystick  <= '0;
            r_connected <= '0;
            if (reset) begin
                r_raw   <= '0;
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_load <= 1'b1;
                    r_clk  <= 1'b0;
                    if (r_cnt == CNT_W'(POLL_PERIOD - 1)) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                        r_load  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (r_cnt == CNT_W'(LOAD_CYCLES - 1)) begin
                        r_state <= SHIFT_LO;
                        r_cnt   <= '0;
                        r_k     <= '0;
                        r_load  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SHIFT_LO: begin
                    // Sample at the end of the low phase so the synchroniser lag stays inside it.
                    if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                        r_raw[r_k] <= r_sync2;
                        r_state    <= SHIFT_HI;
                        r_cnt      <= '0;
                        r_clk      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                        r_cnt <= '0;
                        r_clk <= 1'b0;
                        if (r_k < K_W'(TOTAL - 1)) begin
                            r_k     <= r_k + K_W'(1);
                            r_state <= SHIFT_LO;
                        end else begin
                            r_state  <= LATCH;
                            r_strobe <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LATCH: begin
                    r_joystick  <= w_joy_next;
                    r_connected <= w_det;
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign JOY_CLK      = r_clk;
    assign JOY_LOAD     = r_load;
    assign joystick     = r_joystick;
    assign connected    = r_connected;
    assign frame_strobe = r_strobe;

endmodule

// File: tb/tb_joy_serial_snac.sv
// Directed bench for joy_serial_snac: a two-pad chain with a fast poll rate and a
// one-pad instance used for exact cycle timing, each driven by a shift-register pad model.
module tb_joy_serial_snac;

    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Two-player instance
    logic        reset, enable;
    logic [1:0]  player_en;
    logic        joy_data, joy_clk, joy_load;
    logic [31:0] joystick;
    logic [1:0]  connected;
    logic        frame_strobe;
    logic [23:0] pad_bits;
    logic [23:0] sr = '0;

    // One-player timing instance
    logic        rst_s, en_s;
    logic [0:0]  pen_s;
    logic        s_data, s_clk, s_load;
    logic [15:0] s_joy;
    logic [0:0]  s_conn;
    logic        s_strobe;
    logic [3:0]  pad_s;
    logic [3:0]  sr_s = '0;

    always #5 clk = ~clk;

    joy_serial_snac #(
        .NUM_PLAYERS(2), .BITS_PER_PLAYER(12), .CLK_DIV(4), .POLL_PERIOD(50)
    ) u_dut (
        .clk_sys(clk), .reset(reset), .enable(enable), .player_en(player_en),
        .JOY_DATA(joy_data), .JOY_CLK(joy_clk), .JOY_LOAD(joy_load),
        .joystick(joystick), .connected(connected), .frame_strobe(frame_strobe)
    );

    joy_serial_snac #(
        .NUM_PLAYERS(1), .BITS_PER_PLAYER(4), .CLK_DIV(2), .POLL_PERIOD(10)
    ) u_small (
        .clk_sys(clk), .reset(rst_s), .enable(en_s), .player_en(pen_s),
        .JOY_DATA(s_data), .JOY_CLK(s_clk), .JOY_LOAD(s_load),
        .joystick(s_joy), .connected(s_conn), .frame_strobe(s_strobe)
    );

    // 74HC165 chain: parallel load while LOAD is low, shift toward the output on JOY_CLK rise.
    always @(negedge joy_load or posedge joy_clk) begin
        if (!joy_load) sr <= pad_bits;
        else           sr <= {1'b0, sr[23:1]};
    end
    assign joy_data = sr[0];

    always @(negedge s_load or posedge s_clk) begin
        if (!s_load) sr_s <= pad_s;
        else         sr_s <= {1'b0, sr_s[3:1]};
    end
    assign s_data = sr_s[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag, input int max);
        int n = 0;
        while (frame_strobe !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(frame_strobe), 32'd1);
    endtask

    task automatic wait_load_low(input int max, output int n);
        n = 0;
        while (joy_load !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int hi;
        logic prev;

        reset = 1'b1; enable = 1'b0; player_en = 2'b11;
        pad_bits = {12'hFFF, 12'hFFE};
        rst_s = 1'b1; en_s = 1'b0; pen_s = 1'b1; pad_s = 4'b1010;
        repeat (3) @(negedge clk);

        check("rst_joy",    joystick, 32'h0);
        check("rst_conn",   32'(connected), 32'h0);
        check("rst_load",   32'(joy_load), 32'd1);
        check("rst_clk",    32'(joy_clk), 32'd0);
        check("rst_strobe", 32'(frame_strobe), 32'd0);

        // Exact frame timing on the small instance; cycle 0 is the first cycle out of reset
        en_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        for (int c = 0; c < 46; c++) begin
            check($sformatf("t2_load_c%0d", c), 32'(s_load),
                  32'(((c >= 10 && c <= 13) || (c >= 41 && c <= 44)) ? 1'b0 : 1'b1));
            check($sformatf("t2_clk_c%0d", c), 32'(s_clk),
                  32'((c >= 16 && c <= 29 && ((c - 16) % 4) < 2) ? 1'b1 : 1'b0));
            check($sformatf("t2_strobe_c%0d", c), 32'(s_strobe), 32'(c == 30));
            if (c == 30) check("t2_joy_before", 32'(s_joy), 32'h0);
            if (c == 31) begin
                check("t2_joy",  32'(s_joy), 32'h0005);
                check("t2_conn", 32'(s_conn), 32'd1);
            end
            @(negedge clk);
        end

        // Test 1: P0 button 0 pressed, P1 idle
        reset = 1'b0; enable = 1'b1;
        wait_strobe("t1_strobe", 400);
        check("t1_joy_partial", joystick, 32'h0);
        @(negedge clk);
        check("t1_joy",        joystick, 32'h0000_0001);
        check("t1_conn",       32'(connected), 32'h3);
        check("t1_strobe_len", 32'(frame_strobe), 32'd0);

        // Test 3: player 1 reads all-low -> treated as absent
        pad_bits = {12'h000, 12'hF0F};
        wait_strobe("t3_strobe", 400);
        check("t3_hold", joystick, 32'h0000_0001);
        @(negedge clk);
        check("t3_joy",  joystick, 32'h0000_00F0);
        check("t3_conn", 32'(connected), 32'h1);

        // Test 4: mask changes mid-frame; the value seen in the LATCH cycle wins
        pad_bits  = {12'h800, 12'h800};
        player_en = 2'b10;
        wait_strobe("t4_strobe", 400);
        player_en = 2'b01;
        @(negedge clk);
        check("t4_joy",  joystick, 32'h0000_07FF);
        check("t4_conn", 32'(connected), 32'h3);

        // Test 5: drop enable in the high phase of bit 5
        player_en = 2'b11;
        wait_load_low(100, n);
        check("t5_load_seen", 32'(joy_load), 32'd0);
        hi = 0; prev = 1'b0; n = 0;
        while (hi < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (joy_clk && !prev) hi++;
            prev = joy_clk;
        end
        check("t5_bit5_found", 32'(hi), 32'd6);
        enable = 1'b0;
        @(negedge clk);
        check("t5_clk",    32'(joy_clk), 32'd0);
        check("t5_load",   32'(joy_load), 32'd1);
        check("t5_joy",    joystick, 32'h0);
        check("t5_conn",   32'(connected), 32'h0);
        check("t5_strobe", 32'(frame_strobe), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t5_idle_load",   32'(joy_load), 32'd1);
            check("t5_idle_strobe", 32'(frame_strobe), 32'd0);
        end
        pad_bits = {12'hFFF, 12'hFFC};
        enable = 1'b1;
        wait_load_low(100, n);
        check("t5_reload_delay", 32'(n), 32'd50);

        // Test 6: reset in SHIFT_LO with joystick already showing 0x0003
        wait_strobe("t6_strobe", 300);
        @(negedge clk);
        check("t6_joy_pre", joystick, 32'h0000_0003);
        wait_load_low(100, n);
        n = 0;
        while (joy_load !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_shift", 32'(joy_load), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_joy",    joystick, 32'h0);
        check("t6_conn",   32'(connected), 32'h0);
        check("t6_clk",    32'(joy_clk), 32'd0);
        check("t6_load",   32'(joy_load), 32'd1);
        check("t6_strobe", 32'(frame_strobe), 32'd0);
        reset = 1'b0;
        wait_load_low(100, n);
        check("t6_restart_delay", 32'(n), 32'd50);
        wait_strobe("t6_strobe2", 300);
        @(negedge clk);
        check("t6_joy_after",  joystick, 32'h0000_0003);
        check("t6_conn_after", 32'(connected), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
